// File: rtl/instr_queue.sv
// Instruction queue between decode and dispatch: an in-order FIFO of decoded control words.
// A flush empties the queue and accepts-and-discards any push offered while it is active.
module instr_queue #(
  parameter  int DEPTH = 8,
  parameter  int CW_W  = 89,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNTW  = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_iq,
  input  logic [CW_W-1:0] cw_in,
  output logic            ack_o,
  input  logic            flush_ip,
  output logic            issue_valid,
  output logic [CW_W-1:0] issue_cw,
  input  logic            issue_rdy,
  output logic [CNTW-1:0] count,
  output logic            full,
  output logic            empty,
  output logic            state_dbg
);

  // Handshakes: a push fires on ld_iq & ack_o, a pop fires on issue_valid & issue_rdy,
  // both taking effect at the next rising clk edge; ack_o is combinational.

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW_W-1:0] mem [DEPTH];
  logic [AW-1:0]   head_q, tail_q;
  logic [CNTW-1:0] count_q, count_d;
  logic            full_q, empty_q;
  logic            push, pop, clear;

  always_comb begin
    state_d = state_q;
    ack_o   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    case (state_q)
      RUN: begin
        if (flush_ip) begin
          state_d = FLUSH;
          ack_o   = ld_iq & rst;
          clear   = 1'b1;
        end else begin
          ack_o = ld_iq & ~full_q & rst;
          push  = ld_iq & ~full_q;
          pop   = issue_valid & issue_rdy;
        end
      end
      FLUSH: begin
        if (flush_ip) begin
          ack_o = ld_iq & rst;
          clear = 1'b1;
        end else begin
          // Leaving flush: the queue is empty, so pushes resume this cycle and nothing pops.
          state_d = RUN;
          ack_o   = ld_iq & ~full_q & rst;
          push    = ld_iq & ~full_q;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= (count_d == CNTW'(DEPTH));
      empty_q <= (count_d == '0);
      if (clear) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + AW'(1);
        if (pop)  head_q <= head_q + AW'(1);
      end
    end
  end

  // Storage is not reset; only entries between head and tail are ever read as valid.
  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= cw_in;
  end

  assign issue_valid = (state_q == RUN) & ~empty_q;
  assign issue_cw    = mem[head_q];
  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed scenarios then random traffic, checked every cycle
// against a queue-based reference model.
module tb_instr_queue;
  localparam int DEPTH = 8;
  localparam int CW_W  = 89;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            ld_iq = 1'b0;
  logic [CW_W-1:0] cw_in = '0;
  logic            ack_o;
  logic            flush_ip = 1'b0;
  logic            issue_valid;
  logic [CW_W-1:0] issue_cw;
  logic            issue_rdy = 1'b0;
  logic [CNTW-1:0] count;
  logic            full, empty, state_dbg;

  int tests = 0;
  int fails = 0;
  logic last_ack = 1'b0;
  logic [CW_W-1:0] exp_q[$];

  instr_queue #(.DEPTH(DEPTH), .CW_W(CW_W)) dut (
    .clk(clk), .rst(rst), .ld_iq(ld_iq), .cw_in(cw_in), .ack_o(ack_o),
    .flush_ip(flush_ip), .issue_valid(issue_valid), .issue_cw(issue_cw),
    .issue_rdy(issue_rdy), .count(count), .full(full), .empty(empty),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // invariants
  always @(negedge clk) begin
    assert (count <= CNTW'(DEPTH)) else $error("count out of range: %0d", count);
    assert (full == (count == CNTW'(DEPTH))) else $error("full disagrees with count");
    assert (empty == (count == '0)) else $error("empty disagrees with count");
  end

  task automatic check(input string name, input logic [CW_W-1:0] act, input logic [CW_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW_W-1:0] rand_cw();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[CW_W-1:0];
  endfunction

  // driver: inputs change 1 time unit after the rising edge and hold for one cycle
  task automatic drive(input logic l, input logic [CW_W-1:0] w, input logic f, input logic r);
    ld_iq = l; cw_in = w; flush_ip = f; issue_rdy = r;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b1);
  endtask

  // monitor + scoreboard: compare this cycle's outputs, then advance the model
  always @(negedge clk) begin : monitor
    logic exp_ack;
    int   n;
    if (!rst) exp_q.delete();
    n = exp_q.size();
    if (!rst)          exp_ack = 1'b0;
    else if (flush_ip) exp_ack = ld_iq;
    else               exp_ack = ld_iq && (n < DEPTH);
    check("ack_o", CW_W'(ack_o), CW_W'(exp_ack));
    check("count", CW_W'(count), CW_W'(n));
    check("full", CW_W'(full), CW_W'(n == DEPTH));
    check("empty", CW_W'(empty), CW_W'(n == 0));
    check("issue_valid", CW_W'(issue_valid), CW_W'(n > 0));
    if (n > 0) check("issue_cw", issue_cw, exp_q[0]);
    last_ack = ack_o;
    if (rst) begin
      if (flush_ip) begin
        exp_q.delete();
      end else begin
        if (issue_rdy && n > 0) void'(exp_q.pop_front());
        if (ld_iq && n < DEPTH) exp_q.push_back(cw_in);
      end
    end
  end

  initial begin : stimulus
    logic [CW_W-1:0] w;
    logic l, f, r;
    // reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    // A, B, C back to back with no pops
    drive(1'b1, rand_cw(), 1'b0, 1'b0);
    drive(1'b1, rand_cw(), 1'b0, 1'b0);
    drive(1'b1, rand_cw(), 1'b0, 1'b0);
    idle(2);
    drain(3);

    // fill, stall a 9th push, then pop while full
    for (int i = 0; i < DEPTH; i++) drive(1'b1, rand_cw(), 1'b0, 1'b0);
    w = rand_cw();
    repeat (3) drive(1'b1, w, 1'b0, 1'b0);
    drive(1'b1, w, 1'b0, 1'b1);
    drive(1'b1, w, 1'b0, 1'b0);
    idle(1);
    drain(DEPTH + 1);

    // steady stream from empty
    for (int i = 0; i < 20; i++) drive(1'b1, rand_cw(), 1'b0, 1'b1);
    drain(2);

    // flush with pushes offered, then resume with D
    for (int i = 0; i < 5; i++) drive(1'b1, rand_cw(), 1'b0, 1'b0);
    repeat (3) drive(1'b1, rand_cw(), 1'b1, 1'b0);
    drive(1'b1, rand_cw(), 1'b0, 1'b0);
    idle(1);
    drain(2);

    // async reset mid-stream with four entries queued
    for (int i = 0; i < 4; i++) drive(1'b1, rand_cw(), 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("async_rst_count", CW_W'(count), '0);
    check("async_rst_empty", CW_W'(empty), CW_W'(1));
    check("async_rst_valid", CW_W'(issue_valid), '0);
    drive(1'b1, rand_cw(), 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, rand_cw(), 1'b0, 1'b0);
    drain(4);

    // random traffic; the decoder holds its word until acknowledged
    l = 1'b0;
    w = rand_cw();
    for (int i = 0; i < 600; i++) begin
      if (!(l && !last_ack)) begin
        l = ($urandom_range(0, 99) < 60);
        w = rand_cw();
      end
      f = ($urandom_range(0, 99) < 4);
      r = ($urandom_range(0, 99) < 45);
      drive(l, w, f, r);
    end
    drain(DEPTH + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
